// File: rtl/bbpd_pkg.sv
// rtl/bbpd_pkg.sv - shared types and helpers for the bang-bang phase detector vote filter
package bbpd_pkg;

    typedef enum logic [1:0] {
        DEC_NONE,
        DEC_UP,
        DEC_DOWN
    } dec_t;

    function automatic int cnt_w(input int lanes);
        return $clog2(lanes + 1);
    endfunction

    // Sum clamped to the range of a w-bit two's complement value.
    function automatic int sat_add(input int acc, input int net, input int w);
        int hi;
        int lo;
        int s;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        s  = acc + net;
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

endpackage

// File: rtl/bbpd_vote_filter_if.sv
// rtl/bbpd_vote_filter_if.sv - sample word stream into the phase detector
interface bbpd_vote_filter_if #(
    parameter int LANES = 4
);
    logic             s_valid;
    logic [LANES-1:0] s_early;
    logic [LANES-1:0] s_edge;
    logic [LANES-1:0] s_late;

    modport master (output s_valid, s_early, s_edge, s_late);
    modport slave  (input  s_valid, s_early, s_edge, s_late);
endinterface

// File: rtl/bbpd_vote_sum.sv
// rtl/bbpd_vote_sum.sv - per-lane Alexander votes and glitch flags, registered popcounts
module bbpd_vote_sum
    import bbpd_pkg::*;
#(
    parameter  int LANES = 4,
    localparam int CW    = cnt_w(LANES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic [LANES-1:0] early_i,
    input  logic [LANES-1:0] edge_i,
    input  logic [LANES-1:0] late_i,
    output logic [CW-1:0]    nu_o,
    output logic [CW-1:0]    nd_o,
    output logic             any_t_o,
    output logic             any_g_o,
    output logic             v1_o
);

    logic [LANES-1:0] t_vec;
    logic [LANES-1:0] u_vec;
    logic [LANES-1:0] d_vec;
    logic [LANES-1:0] g_vec;
    logic [CW-1:0]    nu_d, nu_q;
    logic [CW-1:0]    nd_d, nd_q;
    logic             any_t_q, any_g_q, v1_q;

    assign t_vec = early_i ^ late_i;
    assign u_vec = t_vec & (early_i ^ edge_i);
    assign d_vec = t_vec & (late_i ^ edge_i);
    // No data transition, yet the edge sample disagrees with both data samples.
    assign g_vec = ~t_vec & (edge_i ^ early_i);

    always_comb begin
        nu_d = '0;
        nd_d = '0;
        for (int i = 0; i < LANES; i++) begin
            nu_d = nu_d + CW'(u_vec[i]);
            nd_d = nd_d + CW'(d_vec[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nu_q    <= '0;
            nd_q    <= '0;
            any_t_q <= 1'b0;
            any_g_q <= 1'b0;
            v1_q    <= 1'b0;
        end else if (en_i) begin
            if (valid_i) begin
                nu_q    <= nu_d;
                nd_q    <= nd_d;
                any_t_q <= |t_vec;
                any_g_q <= |g_vec;
                v1_q    <= 1'b1;
            end else begin
                v1_q    <= 1'b0;
            end
        end
    end

    assign nu_o    = nu_q;
    assign nd_o    = nd_q;
    assign any_t_o = any_t_q;
    assign any_g_o = any_g_q;
    assign v1_o    = v1_q;

endmodule

// File: rtl/bbpd_vote_filter.sv
// rtl/bbpd_vote_filter.sv - multi-lane bang-bang phase detector with saturating vote accumulator
module bbpd_vote_filter
    import bbpd_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int ACC_W   = 6,
    parameter int THRESH  = 8,
    parameter int WINDOW  = 16,
    parameter int MAX_RUN = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    bbpd_vote_filter_if.slave       s,
    output logic                    up,
    output logic                    down,
    output logic signed [ACC_W-1:0] acc,
    output logic                    no_trans,
    output logic                    glitch
);

    localparam int CW    = cnt_w(LANES);
    localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int RUN_W = $clog2(MAX_RUN + 1);

    if (LANES < 1) begin : g_chk_lanes
        $error("bbpd_vote_filter: LANES must be at least 1");
    end
    if (THRESH < 1 || THRESH > (1 << (ACC_W - 1)) - 1) begin : g_chk_thresh
        $error("bbpd_vote_filter: THRESH out of range for ACC_W");
    end
    if (WINDOW < 2) begin : g_chk_window
        $error("bbpd_vote_filter: WINDOW must be at least 2");
    end
    if (MAX_RUN < 1) begin : g_chk_run
        $error("bbpd_vote_filter: MAX_RUN must be at least 1");
    end

    logic [CW-1:0] nu, nd;
    logic          any_t, any_g, v1;

    bbpd_vote_sum #(
        .LANES (LANES)
    ) u_vote_sum (
        .clk     (clk),
        .rst     (rst),
        .en_i    (en),
        .valid_i (s.s_valid),
        .early_i (s.s_early),
        .edge_i  (s.s_edge),
        .late_i  (s.s_late),
        .nu_o    (nu),
        .nd_o    (nd),
        .any_t_o (any_t),
        .any_g_o (any_g),
        .v1_o    (v1)
    );

    logic signed [ACC_W-1:0] acc_d, acc_q;
    logic [WIN_W-1:0]        win_d, win_q;
    logic [RUN_W-1:0]        run_d, run_q;
    logic                    up_q, down_q, glitch_q, no_trans_q;
    dec_t                    dec;
    int                      net;
    int                      a;

    always_comb begin
        net   = int'(nu) - int'(nd);
        a     = sat_add(int'(acc_q), net, ACC_W);
        dec   = DEC_NONE;
        acc_d = acc_q;
        win_d = win_q;
        if (a >= THRESH) begin
            dec   = DEC_UP;
            acc_d = '0;
            win_d = '0;
        end else if (a <= -THRESH) begin
            dec   = DEC_DOWN;
            acc_d = '0;
            win_d = '0;
        end else if (int'(win_q) == WINDOW - 1) begin
            // Window expired without a decision: discard the partial evidence.
            acc_d = '0;
            win_d = '0;
        end else begin
            acc_d = ACC_W'(a);
            win_d = win_q + WIN_W'(1);
        end

        run_d = run_q;
        if (any_t) begin
            run_d = '0;
        end else if (int'(run_q) < MAX_RUN) begin
            run_d = run_q + RUN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            win_q      <= '0;
            run_q      <= '0;
            up_q       <= 1'b0;
            down_q     <= 1'b0;
            glitch_q   <= 1'b0;
            no_trans_q <= 1'b0;
        end else begin
            up_q     <= 1'b0;
            down_q   <= 1'b0;
            glitch_q <= 1'b0;
            if (en && v1) begin
                acc_q      <= acc_d;
                win_q      <= win_d;
                run_q      <= run_d;
                up_q       <= (dec == DEC_UP);
                down_q     <= (dec == DEC_DOWN);
                glitch_q   <= any_g;
                no_trans_q <= (int'(run_d) >= MAX_RUN);
            end
        end
    end

    assign up       = up_q;
    assign down     = down_q;
    assign acc      = acc_q;
    assign glitch   = glitch_q;
    assign no_trans = no_trans_q;

endmodule

// File: tb/tb_bbpd_vote_filter.sv
// tb/tb_bbpd_vote_filter.sv - randomized and directed checks against a reference model
module tb_bbpd_vote_filter;

    logic clk;
    logic rst;
    logic en;
    logic en2;

    bbpd_vote_filter_if #(.LANES(4)) bus ();
    bbpd_vote_filter_if #(.LANES(8)) bus2 ();

    logic              up, down, no_trans, glitch;
    logic signed [5:0] acc;
    logic              up2, down2, no_trans2, glitch2;
    logic signed [3:0] acc2;

    bbpd_vote_filter dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .s        (bus),
        .up       (up),
        .down     (down),
        .acc      (acc),
        .no_trans (no_trans),
        .glitch   (glitch)
    );

    bbpd_vote_filter #(
        .LANES   (8),
        .ACC_W   (4),
        .THRESH  (7),
        .WINDOW  (16),
        .MAX_RUN (32)
    ) dut2 (
        .clk      (clk),
        .rst      (rst),
        .en       (en2),
        .s        (bus2),
        .up       (up2),
        .down     (down2),
        .acc      (acc2),
        .no_trans (no_trans2),
        .glitch   (glitch2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: accumulator, window and run counts, one word in flight.
    int m_acc = 0, m_win = 0, m_run = 0;
    bit p_v = 0, p_t = 0, p_g = 0;
    int p_nu = 0, p_nd = 0;
    int e_up = 0, e_down = 0, e_gl = 0, e_acc = 0, e_nt = 0;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit e, input bit v,
                              input logic [3:0] ea, input logic [3:0] ed, input logic [3:0] la);
        int a;
        if (r) begin
            m_acc = 0; m_win = 0; m_run = 0;
            p_v = 0; p_t = 0; p_g = 0; p_nu = 0; p_nd = 0;
            e_up = 0; e_down = 0; e_gl = 0; e_nt = 0;
        end else begin
            e_up = 0; e_down = 0; e_gl = 0;
            if (e) begin
                if (p_v) begin
                    a = m_acc + p_nu - p_nd;
                    if (a > 31) a = 31;
                    if (a < -32) a = -32;
                    if (a >= 8) begin
                        e_up = 1; m_acc = 0; m_win = 0;
                    end else if (a <= -8) begin
                        e_down = 1; m_acc = 0; m_win = 0;
                    end else if (m_win == 15) begin
                        m_acc = 0; m_win = 0;
                    end else begin
                        m_acc = a; m_win++;
                    end
                    e_gl = p_g;
                    if (p_t) m_run = 0;
                    else if (m_run < 32) m_run++;
                    e_nt = (m_run >= 32);
                end
                p_v = v;
                if (v) begin
                    p_nu = 0; p_nd = 0; p_t = 0; p_g = 0;
                    for (int i = 0; i < 4; i++) begin
                        if (ea[i] != la[i]) begin
                            p_t = 1;
                            // Edge already took the new value: clock is late.
                            if (ed[i] == la[i]) p_nu++;
                            else p_nd++;
                        end else if (ed[i] != ea[i]) begin
                            p_g = 1;
                        end
                    end
                end
            end
        end
        e_acc = m_acc;
    endtask

    task automatic step(input bit r, input bit e, input bit v,
                        input logic [3:0] ea, input logic [3:0] ed, input logic [3:0] la);
        check("up", {31'd0, up}, e_up);
        check("down", {31'd0, down}, e_down);
        check("glitch", {31'd0, glitch}, e_gl);
        check("no_trans", {31'd0, no_trans}, e_nt);
        check("acc", acc, e_acc);
        check("up_down_excl", {31'd0, up & down}, 0);
        rst         = r;
        en          = e;
        bus.s_valid = v;
        bus.s_early = ea;
        bus.s_edge  = ed;
        bus.s_late  = la;
        model_edge(r, e, v, ea, ed, la);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 4'h0, 4'h0, 4'h0);
    endtask

    task automatic drive2(input bit v, input logic [7:0] ea, input logic [7:0] ed,
                          input logic [7:0] la);
        bus2.s_valid = v;
        bus2.s_early = ea;
        bus2.s_edge  = ed;
        bus2.s_late  = la;
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] ea, ed, la;
        bit r, e, v;
        rst = 1'b1; en = 1'b1; en2 = 1'b1;
        bus.s_valid = 1'b0; bus.s_early = '0; bus.s_edge = '0; bus.s_late = '0;
        bus2.s_valid = 1'b0; bus2.s_early = '0; bus2.s_edge = '0; bus2.s_late = '0;
        repeat (3) @(negedge clk);

        idle(3);

        // Two words of four down votes each.
        step(0, 1, 1, 4'h0, 4'h0, 4'hF);
        step(0, 1, 1, 4'h0, 4'h0, 4'hF);
        idle(3);

        // Single-vote words in both directions, long enough to reach a decision.
        for (int i = 0; i < 16; i++) step(0, 1, 1, 4'h1, 4'h1, 4'h0);
        idle(2);
        for (int i = 0; i < 16; i++) step(0, 1, 1, 4'h1, 4'h0, 4'h0);
        idle(2);

        // Alternating votes: window expiry on the 16th word.
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) step(0, 1, 1, 4'h1, 4'h0, 4'h0);
            else            step(0, 1, 1, 4'h1, 4'h1, 4'h0);
        end
        idle(3);

        // Glitch words with no transitions, then a transition.
        step(0, 1, 1, 4'hF, 4'h5, 4'hF);
        idle(2);
        for (int i = 0; i < 33; i++) step(0, 1, 1, 4'hF, 4'h5, 4'hF);
        idle(2);
        step(0, 1, 1, 4'h1, 4'h0, 4'h0);
        idle(3);

        // Stall mid-stream.
        step(0, 1, 1, 4'h3, 4'h0, 4'h0);
        step(0, 1, 1, 4'h3, 4'h0, 4'h0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 4'h0, 4'h0, 4'hF);
        idle(3);

        // Reset while a down-vote word sits in stage 1.
        step(0, 1, 1, 4'h0, 4'h0, 4'hF);
        step(0, 1, 1, 4'h0, 4'h0, 4'hF);
        step(1, 1, 0, 4'h0, 4'h0, 4'h0);
        idle(3);

        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(0, 299) == 0);
            e = ($urandom_range(0, 9) != 0);
            v = ($urandom_range(0, 4) != 0);
            ea = 4'($urandom);
            la = 4'($urandom);
            ed = 4'($urandom);
            case ($urandom_range(0, 3))
                0: ;
                1: begin la = ~ea; ed = la; end
                2: begin la = ~ea; ed = ea; end
                default: la = ea;
            endcase
            step(r, e, v, ea, ed, la);
        end
        idle(3);

        // Wide, narrow instance: saturation instead of wrap.
        rst = 1'b0; en = 1'b1; bus.s_valid = 1'b0;
        drive2(1, 8'hFF, 8'h00, 8'h00);
        drive2(0, 8'h00, 8'h00, 8'h00);
        check("sat_up", {31'd0, up2}, 1);
        check("sat_down", {31'd0, down2}, 0);
        check("sat_acc", acc2, 0);
        drive2(1, 8'h3F, 8'h00, 8'h00);
        drive2(1, 8'h3F, 8'h00, 8'h00);
        check("partial_acc", acc2, 6);
        check("partial_up", {31'd0, up2}, 0);
        drive2(0, 8'h00, 8'h00, 8'h00);
        check("sat2_up", {31'd0, up2}, 1);
        check("sat2_acc", acc2, 0);
        drive2(1, 8'h00, 8'h00, 8'hFF);
        drive2(0, 8'h00, 8'h00, 8'h00);
        check("neg_down", {31'd0, down2}, 1);
        check("neg_up", {31'd0, up2}, 0);
        drive2(0, 8'h00, 8'h00, 8'h00);
        check("neg_after", {31'd0, down2}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
